// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a BHT of 2-bit saturating counters: IF-stage lookup,
// EX-stage resolve/mispredict detection, BHT training and a saturating mispredict counter.
module branch_resolve_bht #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              lk_valid,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              lk_taken,
  output logic              lk_taken_vld,
  input  logic              rs_valid,
  input  logic [PC_W-1:0]   rs_pc,
  input  logic [2:0]        rs_kind,
  input  logic [DATA_W-1:0] rs_in1,
  input  logic [DATA_W-1:0] rs_in2,
  input  logic              rs_pred_taken,
  input  logic              rs_exception,
  output logic              rs_taken,
  output logic              rs_mispredict,
  output logic              rs_done,
  output logic [CNT_W-1:0]  mispred_cnt,
  output logic              dbg_state
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_BEQ  = 3'd1,
    K_BNE  = 3'd2,
    K_BGEZ = 3'd3,
    K_BLTZ = 3'd4,
    K_TEQ  = 3'd5,
    K_JUMP = 3'd6,
    K_RSVD = 3'd7
  } kind_e;

  // Handshake: lk_valid and rs_valid are single-cycle requests with no backpressure;
  // each one accepted at a posedge is answered exactly one cycle later (lk_taken_vld,
  // rs_done). ready only reports that the init sweep has finished.

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             ready_q;
  logic             lk_taken_q;
  logic             lk_vld_q;
  logic             rs_taken_q;
  logic             rs_mis_q;
  logic             rs_done_q;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d;
  logic [1:0]       bht_q [BHT_DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] rs_idx;
  logic             operands_eq;
  logic             res_taken;
  logic             res_trains;
  logic             res_mis;
  logic             resolve_fire;
  logic [1:0]       bht_cur;
  logic [1:0]       bht_cnt_d;
  logic             bht_we;
  logic [IDX_W-1:0] bht_waddr;
  logic [1:0]       bht_wdata;
  logic             unused_pc_bits;

  assign lk_idx      = lk_pc[IDX_W+1:2];
  assign rs_idx      = rs_pc[IDX_W+1:2];
  assign operands_eq = (rs_in1 == rs_in2);
  assign resolve_fire = rs_valid && (state_q == ST_RUN);

  assign unused_pc_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                            rs_pc[PC_W-1:IDX_W+2], rs_pc[1:0]};

  // Outcome decode; an exception forces a redirect and suppresses training.
  always_comb begin
    res_taken  = 1'b0;
    res_trains = 1'b0;
    case (kind_e'(rs_kind))
      K_BEQ:  begin res_taken = operands_eq;         res_trains = 1'b1; end
      K_BNE:  begin res_taken = !operands_eq;        res_trains = 1'b1; end
      K_BGEZ: begin res_taken = !rs_in1[DATA_W-1];   res_trains = 1'b1; end
      K_BLTZ: begin res_taken = rs_in1[DATA_W-1];    res_trains = 1'b1; end
      K_TEQ:  res_taken = operands_eq;
      K_JUMP: res_taken = 1'b1;
      default: res_taken = 1'b0;
    endcase
    if (rs_exception) begin
      res_taken  = 1'b1;
      res_trains = 1'b0;
    end
    res_mis = rs_exception || (res_taken ^ rs_pred_taken);
  end

  assign bht_cur = bht_q[rs_idx];

  always_comb begin
    bht_cnt_d = bht_cur;
    if (res_taken) begin
      if (bht_cur != 2'b11) bht_cnt_d = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_cnt_d = bht_cur - 2'b01;
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (resolve_fire && res_mis && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  // Single write port shared by the init sweep and resolve training.
  always_comb begin
    bht_we    = 1'b0;
    bht_waddr = rs_idx;
    bht_wdata = bht_cnt_d;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        bht_we    = 1'b1;
        bht_waddr = ptr_q;
        bht_wdata = 2'b01;
      end else if (resolve_fire && res_trains) begin
        bht_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bht_we) bht_q[bht_waddr] <= bht_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      ptr_q         <= '0;
      ready_q       <= 1'b0;
      lk_taken_q    <= 1'b0;
      lk_vld_q      <= 1'b0;
      rs_taken_q    <= 1'b0;
      rs_mis_q      <= 1'b0;
      rs_done_q     <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      // Lookup reads the pre-write array, so a same-cycle resolve is not visible yet.
      lk_vld_q      <= lk_valid;
      lk_taken_q    <= lk_valid && (state_q == ST_RUN) && bht_q[lk_idx][1];
      rs_done_q     <= resolve_fire;
      rs_mis_q      <= resolve_fire && res_mis;
      if (resolve_fire) rs_taken_q <= res_taken;
      mispred_cnt_q <= mispred_cnt_d;
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == IDX_W'(BHT_DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready         = ready_q;
  assign lk_taken      = lk_taken_q;
  assign lk_taken_vld  = lk_vld_q;
  assign rs_taken      = rs_taken_q;
  assign rs_mispredict = rs_mis_q;
  assign rs_done       = rs_done_q;
  assign mispred_cnt   = mispred_cnt_q;
  assign dbg_state     = state_q;

  a_mis_has_done: assert property (@(posedge clk) disable iff (rst) rs_mispredict |-> rs_done);
  a_lk_qualified: assert property (@(posedge clk) disable iff (rst) lk_taken |-> lk_taken_vld);

endmodule
